// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the program loader: controller state encoding,
//   host command bytes, the acknowledge byte and the lengths (in bytes) of
//   every message the loader sends back to the host.
package program_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LD_CNT0 = 4'd1,
        ST_LD_CNT1 = 4'd2,
        ST_LD_DATA = 4'd3,
        ST_LD_WR   = 4'd4,
        ST_RUN     = 4'd5,
        ST_STEP    = 4'd6,
        ST_CAPTURE = 4'd7,
        ST_TX      = 4'd8
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] ACK_BYTE = 8'h06;

    // Message lengths in bytes.
    localparam logic [3:0] ACK_LEN        = 4'd1;
    localparam logic [3:0] RPT_LEN_PC     = 4'd4;
    localparam logic [3:0] RPT_LEN_PC_CNT = 4'd8;

endpackage

// File: rtl/program_loader_tx_word_serializer.sv
// tx_word_serializer
//   Holds a message of up to 8 bytes and hands it to the byte transmitter
//   LSB first.
//
//   Handshake: a byte moves when o_valid & i_ready are both high at a rising
//   clock edge. While o_valid is high and i_ready is low, o_data and o_valid
//   do not change. After an accept the next byte is presented in the
//   following cycle.
//
// Ports
//   i_clock, i_reset  clock, synchronous active-high reset
//   i_load            capture i_value / i_len and start sending
//   i_len             number of bytes to send (1..8)
//   i_value           message, byte 0 in bits [7:0]
//   i_ready           transmitter ready
//   o_data, o_valid   byte on offer
//   o_done            high in the cycle whose edge accepts the last byte
module tx_word_serializer (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [3:0]  i_len,
    input  logic [63:0] i_value,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_done
);

    logic [63:0] r_shift;
    logic [3:0]  r_left;
    logic        r_valid;
    logic        w_accept;

    assign w_accept = r_valid & i_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_shift <= '0;
            r_left  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_value;
            r_left  <= i_len;
            r_valid <= (i_len != 4'd0);
        end else if (w_accept) begin
            r_shift <= {8'h00, r_shift[63:8]};
            r_left  <= r_left - 4'd1;
            if (r_left == 4'd1) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data  = r_shift[7:0];
    assign o_valid = r_valid;
    // Only consumed by the controller FSM, never by a top-level output.
    assign o_done  = w_accept & (r_left == 4'd1);

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Host-side controller between a byte link and the CPU core. It loads a
//   program into instruction memory through the debug write port, runs the
//   core freely or one step at a time through o_valid, and reports the
//   program counter back to the host.
//
//   Optional feature: define PROGRAM_LOADER_CYCLE_COUNT_EN to count the
//   cycles with o_valid high since the last run/step command and append the
//   32-bit count (LSB first) to every PC report.
//
// Ports
//   i_clock, i_reset       clock, synchronous active-high reset
//   i_rx_data, i_rx_valid  received byte and its one-cycle strobe
//   o_tx_data, o_tx_valid  byte to transmit, held until accepted
//   i_tx_ready             transmitter accepts on o_tx_valid & i_tx_ready
//   o_instrmem_addr/data/we  instruction memory debug write port
//   o_valid                core advance enable
//   i_halt                 core has retired HALT (level)
//   i_pc                   core system PC
//   o_busy                 controller is not idle
//   o_dbg_state            current controller state (state_t encoding)
module program_loader
    import program_loader_pkg::*;
#(
    parameter int N_ADDR  = 2048,
    parameter int NB_REG  = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic [15:0]        o_instrmem_addr,
    output logic [NB_REG-1:0]  o_instrmem_data,
    output logic [3:0]         o_instrmem_we,
    output logic               o_valid,
    input  logic               i_halt,
    input  logic [NB_REG-1:0]  i_pc,
    output logic               o_busy,
    output logic [3:0]         o_dbg_state
);

    localparam logic [31:0] LP_N_ADDR = 32'(N_ADDR);

    state_t              r_state, w_state_next;
    logic [15:0]         r_word_cnt, w_word_cnt_next;
    logic [15:0]         r_word_total, w_word_total_next;
    logic [1:0]          r_byte_cnt, w_byte_cnt_next;
    logic [NB_REG-1:0]   r_word, w_word_next;
    logic                r_wait, w_wait_next;
    logic                r_valid, w_valid_next;
    logic [3:0]          r_we, w_we_next;
    logic [15:0]         r_addr, w_addr_next;
    logic [NB_REG-1:0]   r_data, w_data_next;

    logic                w_ser_load;
    logic [3:0]          w_ser_len;
    logic [63:0]         w_ser_value;
    logic                w_ser_done;
    logic [63:0]         w_report;
    logic                w_in_range;

`ifdef PROGRAM_LOADER_CYCLE_COUNT_EN
    localparam logic [3:0] LP_RPT_LEN = RPT_LEN_PC_CNT;
    logic [31:0] r_cycle_cnt;

    // Cleared when a run/step command is accepted, then counts every cycle
    // the core is allowed to advance.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cycle_cnt <= '0;
        end else if ((r_state == ST_IDLE) && i_rx_valid &&
                     ((i_rx_data == CMD_RUN) || (i_rx_data == CMD_STEP))) begin
            r_cycle_cnt <= '0;
        end else if (r_valid) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign w_report = {r_cycle_cnt, i_pc};
`else
    localparam logic [3:0] LP_RPT_LEN = RPT_LEN_PC;
    assign w_report = {32'd0, i_pc};
`endif

    assign w_in_range = ({16'd0, r_word_cnt} < LP_N_ADDR);

    always_comb begin
        w_state_next      = r_state;
        w_word_cnt_next   = r_word_cnt;
        w_word_total_next = r_word_total;
        w_byte_cnt_next   = r_byte_cnt;
        w_word_next       = r_word;
        w_wait_next       = r_wait;
        w_valid_next      = 1'b0;
        w_we_next         = 4'h0;
        w_addr_next       = r_addr;
        w_data_next       = r_data;
        w_ser_load        = 1'b0;
        w_ser_len         = ACK_LEN;
        w_ser_value       = {56'd0, ACK_BYTE};

        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        w_state_next      = ST_LD_CNT0;
                        w_word_cnt_next   = '0;
                        w_word_total_next = '0;
                        w_byte_cnt_next   = '0;
                    end else if (i_rx_data == CMD_RUN) begin
                        w_state_next = ST_RUN;
                        w_valid_next = 1'b1;
                    end else if (i_rx_data == CMD_STEP) begin
                        // A halted core gets no pulse; just report its PC.
                        if (i_halt) begin
                            w_state_next = ST_CAPTURE;
                            w_wait_next  = 1'b0;
                        end else begin
                            w_state_next = ST_STEP;
                            w_valid_next = 1'b1;
                        end
                    end
                end
            end
            ST_LD_CNT0: begin
                if (i_rx_valid) begin
                    w_word_total_next[7:0] = i_rx_data;
                    w_state_next           = ST_LD_CNT1;
                end
            end
            ST_LD_CNT1: begin
                if (i_rx_valid) begin
                    w_word_total_next[15:8] = i_rx_data;
                    if ({i_rx_data, r_word_total[7:0]} == 16'd0) begin
                        w_state_next = ST_TX;
                        w_ser_load   = 1'b1;
                    end else begin
                        w_state_next = ST_LD_DATA;
                    end
                end
            end
            ST_LD_DATA: begin
                if (i_rx_valid) begin
                    w_word_next[{r_byte_cnt, 3'b000} +: 8] = i_rx_data;
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_state_next = ST_LD_WR;
                        // Out-of-range words are consumed but never written.
                        if (w_in_range) begin
                            w_we_next   = 4'hF;
                            w_addr_next = r_word_cnt;
                            w_data_next = w_word_next;
                        end
                    end
                end
            end
            ST_LD_WR: begin
                w_word_cnt_next = r_word_cnt + 16'd1;
                if ((r_word_cnt + 16'd1) == r_word_total) begin
                    w_state_next = ST_TX;
                    w_ser_load   = 1'b1;
                end else begin
                    w_state_next = ST_LD_DATA;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    w_state_next = ST_CAPTURE;
                    w_wait_next  = 1'b0;
                end else begin
                    w_valid_next = 1'b1;
                end
            end
            ST_STEP: begin
                w_state_next = ST_CAPTURE;
                w_wait_next  = 1'b0;
            end
            ST_CAPTURE: begin
                // Two edges of settling so the fetch PC reflects the last
                // advance before it is sampled.
                if (r_wait) begin
                    w_state_next = ST_TX;
                    w_ser_load   = 1'b1;
                    w_ser_len    = LP_RPT_LEN;
                    w_ser_value  = w_report;
                end else begin
                    w_wait_next = 1'b1;
                end
            end
            ST_TX: begin
                if (w_ser_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_word_cnt   <= '0;
            r_word_total <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_wait       <= 1'b0;
            r_valid      <= 1'b0;
            r_we         <= 4'h0;
            r_addr       <= '0;
            r_data       <= '0;
        end else begin
            r_state      <= w_state_next;
            r_word_cnt   <= w_word_cnt_next;
            r_word_total <= w_word_total_next;
            r_byte_cnt   <= w_byte_cnt_next;
            r_word       <= w_word_next;
            r_wait       <= w_wait_next;
            r_valid      <= w_valid_next;
            r_we         <= w_we_next;
            r_addr       <= w_addr_next;
            r_data       <= w_data_next;
        end
    end

    tx_word_serializer u_tx_ser (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (w_ser_load),
        .i_len   (w_ser_len),
        .i_value (w_ser_value),
        .i_ready (i_tx_ready),
        .o_data  (o_tx_data),
        .o_valid (o_tx_valid),
        .o_done  (w_ser_done)
    );

    assign o_instrmem_we   = r_we;
    assign o_instrmem_addr = r_addr;
    assign o_instrmem_data = r_data;
    assign o_valid         = r_valid;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_dbg_state     = r_state;

endmodule
